conv_window_seq: RTL

//  Sequencer that drives custom_module through one full 2x2 convolution of a 4x4 input with a 3x3 kernel.
//  Per window it generates the nine 4-bit s0_* element selects and the init pulse, then captures custom_module's 8-bit out.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_sel_gen.sv | 26 ++
 rtl/conv_window_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 2x2 convolution window sequencer.
//   MAT_IN  : input matrix dimension (4x4)
//   MAT_K   : kernel dimension (3x3)
//   MAT_OUT : output matrix dimension (2x2)
//   SEL_W   : width of one element select, {col[1:0], row[1:0]}
//   state_t : sequencer FSM states
package conv_pkg;

    localparam int MAT_IN  = 4;
    localparam int MAT_K   = 3;
    localparam int MAT_OUT = 2;
    localparam int SEL_W   = 4;
    localparam int IDX_W   = 2;
    localparam int RES_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FIRE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/conv_sel_gen.sv
// Combinational select generator.
// For a window index it produces the nine element selects, one per kernel
// tap (i,j). The window index encodes the output origin: idx[1] is the row
// origin r0 and idx[0] is the column origin c0.
//   idx : window index 0..3 (c11, c12, c21, c22)
//   sel : nine selects, sel[i*MAT_K+j] = {c0+j, r0+i} for zero-based i,j
module conv_sel_gen
    import conv_pkg::*;
(
    input  logic [IDX_W-1:0]                   idx,
    output logic [MAT_K*MAT_K-1:0][SEL_W-1:0]  sel
);

    // Origin is at most 1 and tap offset at most 2, so the 2-bit sums
    // top out at 3 and never wrap.
    for (genvar i = 0; i < MAT_K; i++) begin : g_row
        for (genvar j = 0; j < MAT_K; j++) begin : g_col
            logic [1:0] row;
            logic [1:0] col;
            assign row = {1'b0, idx[1]} + 2'(i);
            assign col = {1'b0, idx[0]} + 2'(j);
            assign sel[i*MAT_K+j] = {col, row};
        end
    end

endmodule

// File: rtl/conv_window_seq.sv
// Sequencer that walks custom_module through one full 2x2 convolution of a
// 4x4 input with a 3x3 kernel. For each window it drives the nine element
// selects, waits SETTLE_CYC cycles, pulses init, waits LAT_CYC cycles and
// captures the 8-bit result.
// Ports:
//   clk       : clock, all state changes on rising edge
//   rst       : synchronous active-high reset
//   start     : request one convolution, honoured only in IDLE
//   result_in : custom_module output
//   s0_11..33 : element selects {col,row} for kernel tap (i,j)
//   init      : one-cycle pulse per window
//   busy      : high from the cycle after start is accepted through DONE
//   done      : one-cycle pulse once all four results are captured
//   c11..c22  : captured window results, held until the next accepted start
module conv_window_seq
    import conv_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned LAT_CYC    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RES_W-1:0] result_in,
    output logic [SEL_W-1:0] s0_11,
    output logic [SEL_W-1:0] s0_12,
    output logic [SEL_W-1:0] s0_13,
    output logic [SEL_W-1:0] s0_21,
    output logic [SEL_W-1:0] s0_22,
    output logic [SEL_W-1:0] s0_23,
    output logic [SEL_W-1:0] s0_31,
    output logic [SEL_W-1:0] s0_32,
    output logic [SEL_W-1:0] s0_33,
    output logic             init,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] c11,
    output logic [RES_W-1:0] c12,
    output logic [RES_W-1:0] c21,
    output logic [RES_W-1:0] c22
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > LAT_CYC) ? SETTLE_CYC : LAT_CYC;
    localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD    = CNT_W'(LAT_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [MAT_K*MAT_K-1:0][SEL_W-1:0] sel_next;

    // Selects are generated from the upcoming window index so they can be
    // registered on the same edge that enters SETUP.
    conv_sel_gen u_sel_gen (
        .idx (idx_next),
        .sel (sel_next)
    );

    // Next-state logic. The down-counter is loaded with (cycles-1) on entry
    // to SETUP and WAIT so each of those states lasts exactly its count.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    idx_next   = '0;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = FIRE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            FIRE: begin
                state_next = WAIT;
                cnt_next   = LAT_LOAD;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (idx == IDX_W'(3)) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx + 1'b1;
                    cnt_next   = SETTLE_LOAD;
                    state_next = SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs. Control outputs are computed from the
    // next state so they line up with the state they describe; selects are
    // loaded only while heading into SETUP and otherwise hold, so they stay
    // put through FIRE, WAIT, CAPTURE and afterwards in DONE/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            init  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s0_11 <= '0;
            s0_12 <= '0;
            s0_13 <= '0;
            s0_21 <= '0;
            s0_22 <= '0;
            s0_23 <= '0;
            s0_31 <= '0;
            s0_32 <= '0;
            s0_33 <= '0;
            c11   <= '0;
            c12   <= '0;
            c21   <= '0;
            c22   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
            init  <= (state_next == FIRE);
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);

            if (state_next == SETUP) begin
                s0_11 <= sel_next[0];
                s0_12 <= sel_next[1];
                s0_13 <= sel_next[2];
                s0_21 <= sel_next[3];
                s0_22 <= sel_next[4];
                s0_23 <= sel_next[5];
                s0_31 <= sel_next[6];
                s0_32 <= sel_next[7];
                s0_33 <= sel_next[8];
            end

            if (state == IDLE && start) begin
                c11 <= '0;
                c12 <= '0;
                c21 <= '0;
                c22 <= '0;
            end else if (state == CAPTURE) begin
                case (idx)
                    2'd0:    c11 <= result_in;
                    2'd1:    c12 <= result_in;
                    2'd2:    c21 <= result_in;
                    default: c22 <= result_in;
                endcase
            end
        end
    end

endmodule
